// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
//   Bus bundle between the instruction-fetch queue and its neighbours
//   (program loader, branch logic, decode).
//
//   Signals (direction seen from the fetch unit, i.e. the slave modport):
//     wr_en           in   program-load write strobe
//     wr_addr         in   word index to write
//     wr_data         in   instruction to write
//     redirect_valid  in   branch/jump taken: flush and refetch
//     redirect_pc     in   new byte PC (bits [1:0] ignored)
//     out_ready       in   decode accepts the head entry
//     out_valid       out  head entry valid
//     out_instruction out  head instruction
//     out_pc          out  byte PC of the head instruction
//     fault           out  sticky fetch fault
//
//   master : driven by the loader/branch/decode side
//   slave  : the fetch unit itself
// ---------------------------------------------------------------------------
interface ifetch_queue_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH+1:0] redirect_pc;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH+1:0] out_pc;
  logic                  fault;

  modport master (
    output wr_en, wr_addr, wr_data, redirect_valid, redirect_pc, out_ready,
    input  out_valid, out_instruction, out_pc, fault
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, redirect_valid, redirect_pc, out_ready,
    output out_valid, out_instruction, out_pc, fault
  );

endinterface

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch unit: writable instruction memory (synchronous,
//   read-first), a fetch PC, and a prefetch FIFO that hands {pc, instruction}
//   pairs to decode over a valid/ready handshake.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ifetch_queue_if.slave (program-load write port, branch redirect,
//            decode handshake, sticky fault)
//
//   Parameters:
//     ADDR_WIDTH  word-index width (memory holds 2**ADDR_WIDTH words)
//     DATA_WIDTH  instruction width
//     FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//     RESET_PC    first byte address fetched after reset
//
//   Build option:
//     IFETCH_RANGE_CHECK_EN  when defined, issuing the top memory word sets a
//                            sticky fault and stops further issue until a
//                            redirect or reset. When undefined the PC wraps
//                            silently to 0 and fault is tied low.
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.slave bus
);

  localparam int PCW  = ADDR_WIDTH + 2;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;

  localparam logic [PCW-1:0]  RESET_PC_C = PCW'(RESET_PC) & ~PCW'(3);
  localparam logic [CNTW:0]   DEPTH_C    = (CNTW+1)'(FIFO_DEPTH);

  // instruction memory and its read register
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // fetch pointer and the one in-flight read
  logic [PCW-1:0]        r_fetch_pc;
  logic [PCW-1:0]        r_rd_pc;
  logic                  r_inflight;

  // prefetch FIFO
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PCW-1:0]        r_fifo_pc   [FIFO_DEPTH];
  logic [PTRW-1:0]       r_wr_ptr;
  logic [PTRW-1:0]       r_rd_ptr;
  logic [CNTW-1:0]       r_count;

  // last head shown, presented while the FIFO is empty
  logic [DATA_WIDTH-1:0] r_last_instr;
  logic [PCW-1:0]        r_last_pc;

  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_space;
  logic                  w_issue;
  logic                  w_fault;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [PCW-1:0]        w_redirect_pc;
  logic [CNTW:0]         w_occupancy;

  assign w_rd_idx      = r_fetch_pc[PCW-1:2];
  assign w_redirect_pc = bus.redirect_pc & ~PCW'(3);
  assign w_empty       = (r_count == '0);

  // A redirect cancels both the pop and the push of its cycle.
  assign w_pop  = !w_empty && bus.out_ready && !bus.redirect_valid;
  assign w_push = r_inflight && !bus.redirect_valid;

  // The in-flight read counts as occupied so its data always has a slot.
  assign w_occupancy = {1'b0, r_count} + {{CNTW{1'b0}}, r_inflight};
  assign w_space     = (w_occupancy < DEPTH_C);
  assign w_issue     = w_space && !bus.redirect_valid && !w_fault;

  // Memory: write and read share the edge; non-blocking read sees old data.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[w_rd_idx];
    end
  end

  // FIFO storage needs no reset: the count says what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_rd_data;
      r_fifo_pc[r_wr_ptr]   <= r_rd_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC_C;
      r_rd_pc      <= '0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else begin
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_inflight <= 1'b0;
        r_wr_ptr   <= r_rd_ptr;
        r_count    <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + PCW'(4);
          r_rd_pc    <= r_fetch_pc;
        end
        r_inflight <= w_issue;
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTRW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTRW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNTW'(1);
          2'b01:   r_count <= r_count - CNTW'(1);
          default: r_count <= r_count;
        endcase
      end
      // Track what is on the outputs so it can be held once the FIFO drains
      // or is flushed.
      if (!w_empty) begin
        r_last_instr <= r_fifo_data[r_rd_ptr];
        r_last_pc    <= r_fifo_pc[r_rd_ptr];
      end
    end
  end

`ifdef IFETCH_RANGE_CHECK_EN
  logic r_fault;
  logic w_top;

  assign w_top = &r_fetch_pc[PCW-1:2];

  // The top word itself is still fetched; only the wrap past it is refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fault <= 1'b0;
    end else if (w_issue && w_top) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign bus.out_valid       = !w_empty;
  assign bus.out_instruction = w_empty ? r_last_instr : r_fifo_data[r_rd_ptr];
  assign bus.out_pc          = w_empty ? r_last_pc    : r_fifo_pc[r_rd_ptr];
  assign bus.fault           = w_fault;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int AW  = 6;
  localparam int AWB = 3;
  localparam int DW  = 32;

`ifdef IFETCH_RANGE_CHECK_EN
  localparam logic FLT = 1'b1;
`else
  localparam logic FLT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW)) ifa ();
  ifetch_queue_if #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW)) ifb ();

  ifetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESET_PC(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  ifetch_queue #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESET_PC(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic head_a(input string tag, input logic [7:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 64'(ifa.out_valid), 64'(1));
    chk({tag, "_pc"},    64'(ifa.out_pc), 64'(pc));
    chk({tag, "_instr"}, 64'(ifa.out_instruction), 64'(ins));
  endtask

  task automatic head_b(input string tag, input logic [4:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 64'(ifb.out_valid), 64'(1));
    chk({tag, "_pc"},    64'(ifb.out_pc), 64'(pc));
    chk({tag, "_instr"}, 64'(ifb.out_instruction), 64'(ins));
  endtask

  initial begin
    rst_n              = 1'b0;
    ifa.wr_en          = 1'b0;
    ifa.wr_addr        = '0;
    ifa.wr_data        = '0;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = '0;
    ifa.out_ready      = 1'b1;
    ifb.wr_en          = 1'b0;
    ifb.wr_addr        = '0;
    ifb.wr_data        = '0;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = '0;
    ifb.out_ready      = 1'b1;

    // program load during reset
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = AW'(i);
      ifa.wr_data = 32'h1000_0000 + 32'(i);
      if (i < 8) begin
        ifb.wr_en   = 1'b1;
        ifb.wr_addr = AWB'(i);
        ifb.wr_data = 32'h2000_0000 + 32'(i);
      end else begin
        ifb.wr_en = 1'b0;
      end
    end
    @(negedge clk);
    ifa.wr_en = 1'b0;
    ifb.wr_en = 1'b0;

    chk("rst_valid", 64'(ifa.out_valid), 64'(0));
    chk("rst_instr", 64'(ifa.out_instruction), 64'(0));
    chk("rst_pc",    64'(ifa.out_pc), 64'(0));
    chk("rst_fault", 64'(ifa.fault), 64'(0));

    // first fetch latency and streaming
    rst_n = 1'b1;
    @(negedge clk);
    chk("lat_c1_valid", 64'(ifa.out_valid), 64'(0));
    @(negedge clk);
    head_a("stream0", 8'h00, 32'h1000_0000);
    @(negedge clk);
    head_a("stream1", 8'h04, 32'h1000_0001);
    @(negedge clk);
    head_a("stream2", 8'h08, 32'h1000_0002);

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(ifa.out_valid), 64'(0));
    chk("midrst_fault", 64'(ifa.fault), 64'(0));
    chk("midrst_pc",    64'(ifa.out_pc), 64'(0));
    ifa.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // back-pressure: FIFO fills, head held at RESET_PC
    for (int i = 0; i < 10; i++) @(negedge clk);
    head_a("hold", 8'h00, 32'h1000_0000);
    ifa.out_ready = 1'b1;
    @(negedge clk);
    head_a("drain1", 8'h04, 32'h1000_0001);
    @(negedge clk);
    head_a("drain2", 8'h08, 32'h1000_0002);
    @(negedge clk);
    head_a("drain3", 8'h0C, 32'h1000_0003);
    @(negedge clk);
    head_a("drain4", 8'h10, 32'h1000_0004);
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    head_a("full_head", 8'h10, 32'h1000_0004);

    // redirect while full, with a pop in the same cycle
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 8'h14;
    ifa.out_ready      = 1'b1;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    chk("redir_c1_valid", 64'(ifa.out_valid), 64'(0));
    chk("redir_c1_pc_hold", 64'(ifa.out_pc), 64'(8'h10));
    @(negedge clk);
    chk("redir_c2_valid", 64'(ifa.out_valid), 64'(0));
    @(negedge clk);
    head_a("redir_first", 8'h14, 32'h1000_0005);
    @(negedge clk);
    head_a("redir_second", 8'h18, 32'h1000_0006);

    // write to the word being read in the same cycle: old data returned
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 8'h0C;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    ifa.wr_en          = 1'b1;
    ifa.wr_addr        = AW'(3);
    ifa.wr_data        = 32'hDEAD_BEEF;
    @(negedge clk);
    ifa.wr_en = 1'b0;
    @(negedge clk);
    head_a("rdfirst_old", 8'h0C, 32'h1000_0003);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 8'h0E;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    head_a("rdfirst_new", 8'h0C, 32'hDEAD_BEEF);

    // back-to-back redirects: the last one wins
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 8'h20;
    @(negedge clk);
    ifa.redirect_pc    = 8'h08;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    chk("b2b_valid", 64'(ifa.out_valid), 64'(0));
    @(negedge clk);
    @(negedge clk);
    head_a("b2b_first", 8'h08, 32'h1000_0002);
    @(negedge clk);
    head_a("b2b_second", 8'h0C, 32'hDEAD_BEEF);

    // top-of-memory behaviour on the small instance
    ifb.redirect_valid = 1'b1;
    ifb.redirect_pc    = 5'h1C;
    @(negedge clk);
    ifb.redirect_valid = 1'b0;
    chk("wrap_c1_valid", 64'(ifb.out_valid), 64'(0));
    chk("wrap_c1_fault", 64'(ifb.fault), 64'(0));
    @(negedge clk);
    chk("wrap_c2_valid", 64'(ifb.out_valid), 64'(0));
    chk("wrap_c2_fault", 64'(ifb.fault), 64'(FLT));
    @(negedge clk);
    head_b("wrap_top", 5'h1C, 32'h2000_0007);
    chk("wrap_top_fault", 64'(ifb.fault), 64'(FLT));
    @(negedge clk);
`ifdef IFETCH_RANGE_CHECK_EN
    chk("wrap_after_valid", 64'(ifb.out_valid), 64'(0));
    chk("wrap_after_pc_hold", 64'(ifb.out_pc), 64'(5'h1C));
`else
    head_b("wrap_after", 5'h00, 32'h2000_0000);
`endif
    chk("wrap_after_fault", 64'(ifb.fault), 64'(FLT));
    @(negedge clk);
`ifdef IFETCH_RANGE_CHECK_EN
    chk("wrap_stall_valid", 64'(ifb.out_valid), 64'(0));
`else
    head_b("wrap_next", 5'h04, 32'h2000_0001);
`endif
    chk("wrap_stall_fault", 64'(ifb.fault), 64'(FLT));

    // redirect clears the fault and resumes fetch
    ifb.redirect_valid = 1'b1;
    ifb.redirect_pc    = 5'h04;
    @(negedge clk);
    ifb.redirect_valid = 1'b0;
    chk("clr_fault", 64'(ifb.fault), 64'(0));
    @(negedge clk);
    @(negedge clk);
    head_b("resume", 5'h04, 32'h2000_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
